// File: rtl/seq_notas_pkg.sv
// Shared definitions for the melody sequencer: state codes, the silent note
// code and the default note/pause durations.
package seq_notas_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    TOCA    = 3'd2,
    PAUSA   = 3'd3,
    AVANCA  = 3'd4,
    FIM     = 3'd5
  } estado_t;

  localparam int NOTA_SILENCIO  = 0;
  localparam int T_NOTA_PADRAO  = 50_000_000;
  localparam int T_PAUSA_PADRAO = 12_500_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sequenciador_notas_temporizador.sv
// temporizador_nota: modulo counter shared by the note and pause phases.
// fim_contagem is high on the last counted cycle; the counter wraps to 0 on
// that same edge so the next phase starts from a clean count.
module temporizador_nota #(
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          zera,
  input  logic          conta,
  input  logic [CW-1:0] modulo,
  output logic          fim_contagem
);

  logic [CW-1:0] cont_q;
  logic [CW-1:0] cont_d;

  assign fim_contagem = conta && (cont_q == (modulo - CW'(1)));

  // next count: clear has priority, then count with wrap at terminal value
  always_comb begin
    cont_d = cont_q;
    if (zera) begin
      cont_d = '0;
    end else if (conta) begin
      if (fim_contagem) cont_d = '0;
      else              cont_d = cont_q + CW'(1);
    end
  end

  // count register, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cont_q <= '0;
    else        cont_q <= cont_d;
  end

endmodule

// File: rtl/sequenciador_notas.sv
// sequenciador_notas: plays memory addresses 0..limite on the buzzer output,
// each note held T_NOTA cycles, and pulses fim when done.
// Optional feature macro SEQ_NOTAS_PAUSA_EN: adds a silent PAUSA phase of
// T_PAUSA cycles after each note. Without it, notes are separated only by
// the AVANCA and CARREGA cycles.
module sequenciador_notas
  import seq_notas_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int NOTE_W = 4,
  parameter int T_NOTA = T_NOTA_PADRAO
`ifdef SEQ_NOTAS_PAUSA_EN
  , parameter int T_PAUSA = T_PAUSA_PADRAO
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [NOTE_W-1:0] nota_mem,
  output logic [ADDR_W-1:0] endereco,
  output logic [NOTE_W-1:0] nota_saida,
  output logic              tocando,
  output logic              ocupado,
  output logic              fim,
  output logic [2:0]        db_estado
);

`ifdef SEQ_NOTAS_PAUSA_EN
  localparam int T_MAX = max_int(T_NOTA, T_PAUSA);
`else
  localparam int T_MAX = T_NOTA;
`endif
  localparam int CW = $clog2(T_MAX + 1);

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [ADDR_W-1:0] limite_q, limite_d;
  logic [NOTE_W-1:0] nota_q, nota_d;
  logic              t_zera, t_conta, t_fim;
  logic [CW-1:0]     t_modulo;
  logic              ultimo;

  // the last note is the one at the latched limit; the address never wraps
  assign ultimo = (endereco_q == limite_q);

  temporizador_nota #(.CW(CW)) u_temporizador (
    .clock       (clock),
    .reset       (reset),
    .zera        (t_zera),
    .conta       (t_conta),
    .modulo      (t_modulo),
    .fim_contagem(t_fim)
  );

  // next state, datapath updates and timer control; abortar overrides all
  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    limite_d   = limite_q;
    nota_d     = nota_q;
    t_zera     = 1'b0;
    t_conta    = 1'b0;
    t_modulo   = CW'(T_NOTA);
    case (estado_q)
      OCIOSO: begin
        t_zera = 1'b1;
        if (iniciar) begin
          estado_d   = CARREGA;
          limite_d   = limite;
          endereco_d = '0;
        end
      end
      CARREGA: begin
        nota_d   = nota_mem;
        t_zera   = 1'b1;
        estado_d = TOCA;
      end
      TOCA: begin
        t_conta = 1'b1;
        if (t_fim) begin
`ifdef SEQ_NOTAS_PAUSA_EN
          estado_d = PAUSA;
`else
          estado_d = ultimo ? FIM : AVANCA;
`endif
        end
      end
`ifdef SEQ_NOTAS_PAUSA_EN
      PAUSA: begin
        t_conta  = 1'b1;
        t_modulo = CW'(T_PAUSA);
        if (t_fim) estado_d = ultimo ? FIM : AVANCA;
      end
`endif
      AVANCA: begin
        endereco_d = endereco_q + ADDR_W'(1);
        estado_d   = CARREGA;
      end
      FIM: begin
        endereco_d = '0;
        estado_d   = OCIOSO;
      end
      default: begin
        estado_d   = OCIOSO;
        endereco_d = '0;
      end
    endcase
    if (abortar) begin
      estado_d   = OCIOSO;
      endereco_d = '0;
      t_zera     = 1'b1;
    end
  end

  // state and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      endereco_q <= '0;
      limite_q   <= '0;
      nota_q     <= '0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      nota_q     <= nota_d;
    end
  end

  // Moore outputs decoded from the state register
  always_comb begin
    nota_saida = NOTE_W'(NOTA_SILENCIO);
    if (estado_q == TOCA) nota_saida = nota_q;
    tocando   = (estado_q == TOCA);
    ocupado   = (estado_q != OCIOSO);
    fim       = (estado_q == FIM);
    db_estado = estado_q;
  end

  assign endereco = endereco_q;

endmodule

// File: doc/sequenciador_notas.md
# sequenciador_notas

- Plays the melody stored in the game's sequence memory, addresses 0..`limite`, to the buzzer/Arduino output.
- Holds each note for a fixed number of cycles, then a silent gap, and pulses `fim` when the sequence is done.
- Sits between the main game control unit and the melody memory/Arduino interface.
- Owns the address counter and note timer, so the game FSM issues one `iniciar` pulse instead of stepping each note itself.

## Interface
- `ADDR_W`, 4: memory address width; sequence length up to 2^ADDR_W notes.
- `NOTE_W`, 4: note code width; code 0 = silence.
- `T_NOTA`, 50_000_000: cycles a note is sounded (≥1).
- `T_PAUSA`, 12_500_000: cycles of silence after each note (≥1).

Ports:
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `iniciar` in 1: start playback; sampled only in OCIOSO.
- `abortar` in 1: synchronous abort, any state.
- `limite` in ADDR_W: last address to play; sampled when `iniciar` is accepted.
- `nota_mem` in NOTE_W: memory read data; valid one cycle after `endereco` changes.
- `endereco` out ADDR_W: memory address, registered.
- `nota_saida` out NOTE_W: note to Arduino/buzzer; 0 outside TOCA.
- `tocando` out 1: high in TOCA.
- `ocupado` out 1: high in every state except OCIOSO.
- `fim` out 1: one-cycle pulse, in FIM only.
- `db_estado` out 3: state code, for debug.

## Operation
- States and codes:
  - OCIOSO=0: `iniciar` → CARREGA; latch `limite`; `endereco`=0.
  - CARREGA=1: capture `nota_mem` into the note register; clear timer → TOCA.
  - TOCA=2: `nota_saida`=note register; count T_NOTA cycles → PAUSA.
  - PAUSA=3: output silent; count T_PAUSA cycles. Then → FIM if `endereco`==latched `limite`, else → AVANCA.
  - AVANCA=4: `endereco`+1 → CARREGA.
  - FIM=5: `fim`=1 → OCIOSO; `endereco` cleared to 0.
- Note code 0 in memory: silence for T_NOTA cycles; `tocando` still high.
- `iniciar` outside OCIOSO is ignored.
- `abortar`: next state OCIOSO from any state, `endereco`←0, no `fim` pulse.
- `abortar` and `iniciar` in the same cycle: `abortar` wins.
- `endereco` never wraps: playback stops at the latched `limite`, and `limite`=2^ADDR_W−1 is legal.
- All outputs are Moore (state-decoded) or registered.

## Timing
- Reset value of every output is 0: `endereco`, `nota_saida`, `tocando`, `ocupado`, `fim`, `db_estado`.
- `iniciar` sampled at edge k: CARREGA in cycle k+1, first note on `nota_saida` from cycle k+2.
- Per note: 1 (CARREGA) + T_NOTA + T_PAUSA + 1 (AVANCA, or FIM after the last note) cycles.
- `ocupado` falls the cycle after FIM; a new `iniciar` is accepted in that cycle.
- Reset asserted mid-note clears all outputs immediately (asynchronous).
- Timer counter width: $clog2(max(T_NOTA,T_PAUSA)+1). Terminal count is compared exactly, no off-by-one: TOCA lasts exactly T_NOTA cycles.

## Configuration
- `SEQ_NOTAS_PAUSA_EN` defined: PAUSA state exists as described above.
- Undefined: PAUSA and T_PAUSA are removed. TOCA goes directly to FIM/AVANCA with the same last-address test, and consecutive notes are separated only by the AVANCA and CARREGA cycles, with the output silent during those 2 cycles.

## Structure
- Shared package `seq_notas_pkg`:
  - state enum with the codes listed under Operation;
  - `NOTA_SILENCIO`=0;
  - default T_NOTA/T_PAUSA constants.
- Sub-module `temporizador_nota`: modulo counter with ports `zera`, `conta`, `modulo` (count value in) and `fim_contagem`. One instance, shared by TOCA and PAUSA; its count value is muxed by state.

## Test plan
Bench uses T_NOTA=4, T_PAUSA=2, ADDR_W=3, memory {3,5,7,0,…}, `iniciar` sampled at edge 0.
- Three notes, `limite`=2:
  - `nota_saida` is 3 in cycles 2–5, 5 in cycles 10–13, 7 in cycles 18–21, and 0 elsewhere.
  - `fim` is high in cycle 24 only; `ocupado` is low from cycle 25.
- One note, `limite`=0: 3 in cycles 2–5, `fim` in cycle 8, `endereco` stays 0.
- Abort: `abortar` in cycle 11 (TOCA, note 5) → cycle 12 has `nota_saida`=0, `ocupado`=0, `endereco`=0, and `fim` never pulses. `iniciar` in the same cycle as `abortar` is not accepted.
- Robustness:
  - Extra `iniciar` pulses in cycles 3 and 15 leave the scenario-1 waveform unchanged.
  - `reset`=0 in cycle 4 drives all outputs to 0 asynchronously.
  - Release of reset, then `iniciar`, restarts playback from address 0.
- Macro undefined, `limite`=1: 3 in cycles 2–5, 0 in cycles 6–7, 5 in cycles 8–11, `fim` in cycle 12.
- `limite`=3 (memory entry 3 = 0): fourth note gives `tocando`=1 with `nota_saida`=0 for 4 cycles, then `fim` is asserted normally.
